// File: rtl/dca_sched_capture.sv
// dca_sched_capture: receive-side monitor for the DCA operation schedule stream.
// Rebuilds the per-row A/B slot masks from the sequencer strobes, checks each
// operation's begin-to-end latency and hands finished rows to a consumer
// through a single-entry valid/ready output register.
module dca_sched_capture #(
    parameter int ROW_COUNT   = 8,
    parameter int SLOT_COUNT  = 8,
    parameter int OPA_LATENCY = 10,
    parameter int OPB_LATENCY = 10,
    localparam int RW = (ROW_COUNT > 1) ? $clog2(ROW_COUNT) : 1,
    localparam int SW = SLOT_COUNT + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 sched_start,
    input  logic                 sched_slot,
    input  logic                 sched_row_end,
    input  logic                 sched_opa_begin,
    input  logic                 sched_opb_begin,
    input  logic                 sched_opa_end,
    input  logic                 sched_opb_end,
    input  logic                 sched_done,
    output logic                 row_valid,
    input  logic                 row_ready,
    output logic [RW-1:0]        row_index,
    output logic [SW-1:0]        row_opa_mask,
    output logic [SW-1:0]        row_opb_mask,
    output logic [ROW_COUNT-1:0] rows_active,
    output logic                 busy,
    output logic                 done_pulse,
    output logic                 err_latency,
    output logic                 err_protocol,
    output logic                 err_overflow
);

    // Row counter must be able to hold ROW_COUNT itself (the "all rows seen" value).
    localparam int CW     = $clog2(ROW_COUNT + 1);
    localparam int XW     = $clog2(SLOT_COUNT + 1);
    localparam int MAXLAT = (OPA_LATENCY > OPB_LATENCY) ? OPA_LATENCY : OPB_LATENCY;
    localparam int LW     = $clog2(MAXLAT + 1);

    localparam logic [CW-1:0] ROW_LAST  = CW'(ROW_COUNT);
    localparam logic [XW-1:0] SLOT_LAST = XW'(SLOT_COUNT);
    localparam logic [LW-1:0] OPA_LM1   = LW'(OPA_LATENCY - 1);
    localparam logic [LW-1:0] OPB_LM1   = LW'(OPB_LATENCY - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    typedef struct packed {
        logic          pend;
        logic [LW-1:0] cnt;
        logic          err_lat;
        logic          err_proto;
    } lat_t;

    // One enabled cycle of a latency channel. The counter value "seen" in a cycle
    // is LAT-1 on the begin cycle and one less each enabled cycle after; the end
    // strobe is legal only when that value is 0. A stored 0 with the op still
    // pending means the due cycle passed without an end.
    function automatic lat_t lat_step(input logic          pend,
                                      input logic [LW-1:0] cnt,
                                      input logic          op_begin,
                                      input logic          op_end,
                                      input logic [LW-1:0] lat_m1);
        lat_t          r;
        logic [LW-1:0] eff;
        r.pend      = pend;
        r.cnt       = cnt;
        r.err_lat   = 1'b0;
        r.err_proto = 1'b0;
        eff         = cnt;
        if (op_begin) begin
            r.err_proto = pend;
            r.pend      = 1'b1;
            r.cnt       = lat_m1;
            if (op_end) begin
                if (lat_m1 == LW'(0)) begin
                    r.pend = 1'b0;
                end else begin
                    r.err_lat = 1'b1;
                end
            end else begin
                r.err_lat = 1'b0;
            end
        end else if (pend) begin
            if (cnt == LW'(0)) begin
                r.err_lat = 1'b1;
                r.pend    = 1'b0;
            end else begin
                eff   = cnt - LW'(1);
                r.cnt = eff;
                if (op_end) begin
                    r.pend    = 1'b0;
                    r.err_lat = (eff != LW'(0));
                end else begin
                    r.err_lat = 1'b0;
                end
            end
        end else begin
            r.err_lat = op_end;
        end
        return r;
    endfunction

    state_t               state_r, state_n;
    logic [XW-1:0]        slot_r, slot_n;
    logic [CW-1:0]        row_r, row_n;
    logic [SW-1:0]        mask_a_r, mask_a_n, mask_b_r, mask_b_n;
    logic [SW-1:0]        mask_a_cur_s, mask_b_cur_s;
    logic                 pend_a_r, pend_a_n, pend_b_r, pend_b_n;
    logic [LW-1:0]        cnt_a_r, cnt_a_n, cnt_b_r, cnt_b_n;
    logic                 row_valid_r, row_valid_n;
    logic [RW-1:0]        row_index_r, row_index_n;
    logic [SW-1:0]        out_a_r, out_a_n, out_b_r, out_b_n;
    logic [ROW_COUNT-1:0] rows_active_r, rows_active_n;
    logic                 done_r, done_n;
    logic                 err_lat_r, err_lat_n;
    logic                 err_proto_r, err_proto_n;
    logic                 err_ovf_r, err_ovf_n;
    logic                 strobe_any_s, do_clear_s, run_s;
    lat_t                 la_s, lb_s;

    // Next-state and next-value logic for the FSM, masks, counters and output register.
    always_comb begin
        state_n       = state_r;
        slot_n        = slot_r;
        row_n         = row_r;
        mask_a_n      = mask_a_r;
        mask_b_n      = mask_b_r;
        pend_a_n      = pend_a_r;
        pend_b_n      = pend_b_r;
        cnt_a_n       = cnt_a_r;
        cnt_b_n       = cnt_b_r;
        row_valid_n   = row_valid_r;
        row_index_n   = row_index_r;
        out_a_n       = out_a_r;
        out_b_n       = out_b_r;
        rows_active_n = rows_active_r;
        done_n        = 1'b0;
        err_lat_n     = err_lat_r;
        err_proto_n   = err_proto_r;
        err_ovf_n     = err_ovf_r;
        do_clear_s    = 1'b0;
        run_s         = 1'b0;

        strobe_any_s = sched_slot | sched_row_end | sched_opa_begin | sched_opb_begin |
                       sched_opa_end | sched_opb_end | sched_done;
        la_s = lat_step(pend_a_r, cnt_a_r, sched_opa_begin, sched_opa_end, OPA_LM1);
        lb_s = lat_step(pend_b_r, cnt_b_r, sched_opb_begin, sched_opb_end, OPB_LM1);
        mask_a_cur_s = mask_a_r | (sched_opa_begin ? (SW'(1) << slot_r) : SW'(0));
        mask_b_cur_s = mask_b_r | (sched_opb_begin ? (SW'(1) << slot_r) : SW'(0));

        // Consumer handshake runs regardless of enable; a row load below overrides it.
        if (row_valid_r && row_ready) begin
            row_valid_n = 1'b0;
        end else begin
            row_valid_n = row_valid_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (enable && sched_start) begin
                    do_clear_s = 1'b1;
                    state_n    = ST_ACTIVE;
                end else if (enable && strobe_any_s) begin
                    err_proto_n = 1'b1;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (enable && sched_start) begin
                    do_clear_s = 1'b1;
                end else if (enable) begin
                    run_s = 1'b1;
                end else begin
                    state_n = ST_ACTIVE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (do_clear_s) begin
            slot_n        = XW'(0);
            row_n         = CW'(0);
            mask_a_n      = SW'(0);
            mask_b_n      = SW'(0);
            rows_active_n = {ROW_COUNT{1'b0}};
            pend_a_n      = 1'b0;
            pend_b_n      = 1'b0;
            cnt_a_n       = LW'(0);
            cnt_b_n       = LW'(0);
            err_lat_n     = 1'b0;
            err_proto_n   = 1'b0;
            err_ovf_n     = 1'b0;
        end else begin
            err_lat_n = err_lat_n;
        end

        if (run_s) begin
            pend_a_n = la_s.pend;
            cnt_a_n  = la_s.cnt;
            pend_b_n = lb_s.pend;
            cnt_b_n  = lb_s.cnt;
            if (la_s.err_lat || lb_s.err_lat) begin
                err_lat_n = 1'b1;
            end else begin
                err_lat_n = err_lat_r;
            end
            if (la_s.err_proto || lb_s.err_proto) begin
                err_proto_n = 1'b1;
            end else begin
                err_proto_n = err_proto_r;
            end
            mask_a_n = mask_a_cur_s;
            mask_b_n = mask_b_cur_s;
            if ((sched_opa_begin || sched_opb_begin) && (row_r < ROW_LAST)) begin
                rows_active_n[row_r[RW-1:0]] = 1'b1;
            end else begin
                rows_active_n = rows_active_r;
            end

            if (sched_row_end) begin
                if ((slot_r != SLOT_LAST) || sched_slot) begin
                    err_proto_n = 1'b1;
                end else begin
                    err_proto_n = err_proto_n;
                end
                slot_n   = XW'(0);
                mask_a_n = SW'(0);
                mask_b_n = SW'(0);
                if (row_r == ROW_LAST) begin
                    // More rows than the schedule holds: nothing sensible to deliver.
                    err_proto_n = 1'b1;
                end else begin
                    row_n = row_r + CW'(1);
                    if (!row_valid_r || row_ready) begin
                        row_valid_n = 1'b1;
                        row_index_n = row_r[RW-1:0];
                        out_a_n     = mask_a_cur_s;
                        out_b_n     = mask_b_cur_s;
                    end else begin
                        err_ovf_n = 1'b1;
                    end
                end
            end else if (sched_slot) begin
                if (slot_r == SLOT_LAST) begin
                    err_proto_n = 1'b1;
                end else begin
                    slot_n = slot_r + XW'(1);
                end
            end else begin
                slot_n = slot_r;
            end

            if (sched_done) begin
                state_n = ST_IDLE;
                done_n  = 1'b1;
                if ((row_n != ROW_LAST) || pend_a_n || pend_b_n) begin
                    err_proto_n = 1'b1;
                end else begin
                    err_proto_n = err_proto_n;
                end
            end else begin
                done_n = 1'b0;
            end
        end else begin
            done_n = 1'b0;
        end
    end

    // State and datapath registers; rst discards everything including a held row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            slot_r        <= XW'(0);
            row_r         <= CW'(0);
            mask_a_r      <= SW'(0);
            mask_b_r      <= SW'(0);
            pend_a_r      <= 1'b0;
            pend_b_r      <= 1'b0;
            cnt_a_r       <= LW'(0);
            cnt_b_r       <= LW'(0);
            row_valid_r   <= 1'b0;
            row_index_r   <= RW'(0);
            out_a_r       <= SW'(0);
            out_b_r       <= SW'(0);
            rows_active_r <= {ROW_COUNT{1'b0}};
            done_r        <= 1'b0;
            err_lat_r     <= 1'b0;
            err_proto_r   <= 1'b0;
            err_ovf_r     <= 1'b0;
        end else begin
            state_r       <= state_n;
            slot_r        <= slot_n;
            row_r         <= row_n;
            mask_a_r      <= mask_a_n;
            mask_b_r      <= mask_b_n;
            pend_a_r      <= pend_a_n;
            pend_b_r      <= pend_b_n;
            cnt_a_r       <= cnt_a_n;
            cnt_b_r       <= cnt_b_n;
            row_valid_r   <= row_valid_n;
            row_index_r   <= row_index_n;
            out_a_r       <= out_a_n;
            out_b_r       <= out_b_n;
            rows_active_r <= rows_active_n;
            done_r        <= done_n;
            err_lat_r     <= err_lat_n;
            err_proto_r   <= err_proto_n;
            err_ovf_r     <= err_ovf_n;
        end
    end

    assign row_valid    = row_valid_r;
    assign row_index    = row_index_r;
    assign row_opa_mask = out_a_r;
    assign row_opb_mask = out_b_r;
    assign rows_active  = rows_active_r;
    assign busy         = (state_r == ST_ACTIVE);
    assign done_pulse   = done_r;
    assign err_latency  = err_lat_r;
    assign err_protocol = err_proto_r;
    assign err_overflow = err_ovf_r;

endmodule

// File: tb/tb_dca_sched_capture.sv
// Directed bench for dca_sched_capture: ROW_COUNT=2, SLOT_COUNT=2. The main
// instance uses latencies 3/3; a second instance on the same stimulus uses an
// A latency of 4 for the enable-gating case.
module tb_dca_sched_capture;

    localparam logic [7:0] ST = 8'h01;
    localparam logic [7:0] SL = 8'h02;
    localparam logic [7:0] RE = 8'h04;
    localparam logic [7:0] AB = 8'h08;
    localparam logic [7:0] BB = 8'h10;
    localparam logic [7:0] AE = 8'h20;
    localparam logic [7:0] BE = 8'h40;
    localparam logic [7:0] DN = 8'h80;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic       sched_start = 1'b0, sched_slot = 1'b0, sched_row_end = 1'b0;
    logic       sched_opa_begin = 1'b0, sched_opb_begin = 1'b0;
    logic       sched_opa_end = 1'b0, sched_opb_end = 1'b0, sched_done = 1'b0;
    logic       row_ready = 1'b1;

    logic       row_valid, busy, done_pulse, err_latency, err_protocol, err_overflow;
    logic [0:0] row_index;
    logic [2:0] row_opa_mask, row_opb_mask;
    logic [1:0] rows_active;

    logic       row_valid_4, busy_4, done_pulse_4, err_latency_4, err_protocol_4, err_overflow_4;
    logic [0:0] row_index_4;
    logic [2:0] row_opa_mask_4, row_opb_mask_4;
    logic [1:0] rows_active_4;

    int n_vec = 0;
    int n_mis = 0;

    dca_sched_capture #(.ROW_COUNT(2), .SLOT_COUNT(2), .OPA_LATENCY(3), .OPB_LATENCY(3)) u_dut (
        .clk(clk), .rst(rst), .enable(enable),
        .sched_start(sched_start), .sched_slot(sched_slot), .sched_row_end(sched_row_end),
        .sched_opa_begin(sched_opa_begin), .sched_opb_begin(sched_opb_begin),
        .sched_opa_end(sched_opa_end), .sched_opb_end(sched_opb_end), .sched_done(sched_done),
        .row_valid(row_valid), .row_ready(row_ready), .row_index(row_index),
        .row_opa_mask(row_opa_mask), .row_opb_mask(row_opb_mask), .rows_active(rows_active),
        .busy(busy), .done_pulse(done_pulse), .err_latency(err_latency),
        .err_protocol(err_protocol), .err_overflow(err_overflow)
    );

    dca_sched_capture #(.ROW_COUNT(2), .SLOT_COUNT(2), .OPA_LATENCY(4), .OPB_LATENCY(3)) u_dut4 (
        .clk(clk), .rst(rst), .enable(enable),
        .sched_start(sched_start), .sched_slot(sched_slot), .sched_row_end(sched_row_end),
        .sched_opa_begin(sched_opa_begin), .sched_opb_begin(sched_opb_begin),
        .sched_opa_end(sched_opa_end), .sched_opb_end(sched_opb_end), .sched_done(sched_done),
        .row_valid(row_valid_4), .row_ready(row_ready), .row_index(row_index_4),
        .row_opa_mask(row_opa_mask_4), .row_opb_mask(row_opb_mask_4), .rows_active(rows_active_4),
        .busy(busy_4), .done_pulse(done_pulse_4), .err_latency(err_latency_4),
        .err_protocol(err_protocol_4), .err_overflow(err_overflow_4)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of strobes, then return 1 time unit after the edge with strobes cleared.
    task automatic drive(input logic [7:0] v, input logic en);
        enable          = en;
        sched_start     = v[0];
        sched_slot      = v[1];
        sched_row_end   = v[2];
        sched_opa_begin = v[3];
        sched_opb_begin = v[4];
        sched_opa_end   = v[5];
        sched_opb_end   = v[6];
        sched_done      = v[7];
        @(posedge clk);
        #1;
        {sched_start, sched_slot, sched_row_end, sched_opa_begin, sched_opb_begin,
         sched_opa_end, sched_opb_end, sched_done} = 8'h00;
        enable = 1'b1;
    endtask

    // Two-row schedule: row 0 has A in slot 0 and B in slot 1, row 1 is empty.
    task automatic run_clean(input string tag);
        drive(ST, 1'b1);
        check_eq({tag, "_busy"}, {31'd0, busy}, 32'd1);
        drive(AB, 1'b1);
        drive(SL, 1'b1);
        drive(BB | AE, 1'b1);
        drive(SL, 1'b1);
        drive(BE | RE, 1'b1);
        check_eq({tag, "_r0_valid"}, {31'd0, row_valid}, 32'd1);
        check_eq({tag, "_r0_index"}, {31'd0, row_index}, 32'd0);
        check_eq({tag, "_r0_amask"}, {29'd0, row_opa_mask}, 32'h1);
        check_eq({tag, "_r0_bmask"}, {29'd0, row_opb_mask}, 32'h2);
        check_eq({tag, "_rows_active"}, {30'd0, rows_active}, 32'h1);
        drive(SL, 1'b1);
        check_eq({tag, "_r0_accepted"}, {31'd0, row_valid}, 32'd0);
        drive(SL, 1'b1);
        drive(RE, 1'b1);
        check_eq({tag, "_r1_valid"}, {31'd0, row_valid}, 32'd1);
        check_eq({tag, "_r1_index"}, {31'd0, row_index}, 32'd1);
        check_eq({tag, "_r1_masks"}, {26'd0, row_opa_mask, row_opb_mask}, 32'h0);
        drive(DN, 1'b1);
        check_eq({tag, "_done_pulse"}, {31'd0, done_pulse}, 32'd1);
        check_eq({tag, "_idle"}, {31'd0, busy}, 32'd0);
        check_eq({tag, "_errs"}, {29'd0, err_latency, err_protocol, err_overflow}, 32'h0);
        check_eq({tag, "_rows_active_end"}, {30'd0, rows_active}, 32'h1);
        drive(8'h00, 1'b1);
        check_eq({tag, "_done_once"}, {31'd0, done_pulse}, 32'd0);
    endtask

    initial begin
        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_outs", {18'd0, row_valid, row_index, row_opa_mask, row_opb_mask, rows_active,
                                busy, done_pulse, err_latency, err_protocol, err_overflow}, 32'h0);
        rst = 1'b0;

        run_clean("clean");

        // A end one enabled cycle early: sticky err_latency until the next start.
        drive(ST, 1'b1);
        drive(AB, 1'b1);
        drive(AE, 1'b1);
        check_eq("early_end_err", {31'd0, err_latency}, 32'd1);
        drive(8'h00, 1'b1);
        drive(8'h00, 1'b1);
        check_eq("early_end_sticky", {31'd0, err_latency}, 32'd1);
        drive(ST, 1'b1);
        check_eq("early_end_cleared", {31'd0, err_latency}, 32'd0);

        // Consumer stalled across two row ends: first row held, second dropped.
        row_ready = 1'b0;
        drive(SL, 1'b1);
        drive(SL, 1'b1);
        drive(RE, 1'b1);
        drive(SL, 1'b1);
        drive(SL, 1'b1);
        drive(RE, 1'b1);
        check_eq("ovf_flag", {31'd0, err_overflow}, 32'd1);
        check_eq("ovf_held_valid", {31'd0, row_valid}, 32'd1);
        row_ready = 1'b1;
        check_eq("ovf_held_index", {31'd0, row_index}, 32'd0);
        drive(8'h00, 1'b1);
        check_eq("ovf_accepted", {31'd0, row_valid}, 32'd0);
        drive(DN, 1'b1);
        check_eq("ovf_done_rows_ok", {31'd0, err_protocol}, 32'd0);

        // Enable gating: A latency 4 instance, end strobes in disabled cycles ignored.
        drive(ST, 1'b1);
        drive(AB, 1'b1);
        drive(AE, 1'b0);
        drive(8'h00, 1'b1);
        drive(AE, 1'b0);
        drive(8'h00, 1'b1);
        drive(AE, 1'b0);
        drive(AE, 1'b1);
        check_eq("gate_lat4_ok", {31'd0, err_latency_4}, 32'd0);
        check_eq("gate_lat3_late", {31'd0, err_latency}, 32'd1);
        drive(8'h00, 1'b1);
        drive(8'h00, 1'b1);
        check_eq("gate_lat4_settled", {31'd0, err_latency_4}, 32'd0);
        check_eq("gate_busy", {31'd0, busy_4}, 32'd1);

        // Missing end: counter reaches 0 without an end, error on the next enabled cycle.
        drive(ST, 1'b1);
        drive(AB, 1'b1);
        drive(8'h00, 1'b1);
        drive(8'h00, 1'b1);
        check_eq("timeout_not_yet", {31'd0, err_latency}, 32'd0);
        drive(8'h00, 1'b1);
        check_eq("timeout_err", {31'd0, err_latency}, 32'd1);

        // Done with no rows completed.
        drive(ST, 1'b1);
        drive(DN, 1'b1);
        check_eq("short_done_proto", {31'd0, err_protocol}, 32'd1);
        check_eq("short_done_pulse", {31'd0, done_pulse}, 32'd1);

        // Row end at slot 1: protocol error but the row is still delivered.
        row_ready = 1'b0;
        drive(ST, 1'b1);
        drive(AB, 1'b1);
        drive(SL, 1'b1);
        drive(RE | AE, 1'b1);
        check_eq("short_row_proto", {31'd0, err_protocol}, 32'd1);
        check_eq("short_row_valid", {31'd0, row_valid}, 32'd1);
        check_eq("short_row_masks", {26'd0, row_opa_mask, row_opb_mask}, 32'h08);
        check_eq("short_row_lat", {31'd0, err_latency}, 32'd0);

        // Asynchronous reset with a held row.
        #2;
        rst = 1'b1;
        #1;
        check_eq("midreset_outs", {18'd0, row_valid, row_index, row_opa_mask, row_opb_mask, rows_active,
                                   busy, done_pulse, err_latency, err_protocol, err_overflow}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        row_ready = 1'b1;

        // Strobe while idle flags a protocol error; the following start clears it.
        drive(SL, 1'b1);
        check_eq("idle_strobe_proto", {31'd0, err_protocol}, 32'd1);
        run_clean("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
